// File: rtl/n64_vbus_tx_pkg.sv
// Shared constants for the N64 multiplexed video bus: VD width, sync-bit positions and
// the 240p timing defaults.
package n64_vbus_tx_pkg;

  localparam int unsigned VdWidth    = 7;
  localparam int unsigned VdVsyncBit = 3;
  localparam int unsigned VdClampBit = 2;
  localparam int unsigned VdHsyncBit = 1;
  localparam int unsigned VdCsyncBit = 0;

  // NTSC 240p
  localparam int unsigned NtscHTotal    = 773;
  localparam int unsigned NtscHSyncLen  = 57;
  localparam int unsigned NtscClampLen  = 8;
  localparam int unsigned NtscHActStart = 108;
  localparam int unsigned NtscHActLen   = 640;
  localparam int unsigned NtscVTotal    = 263;
  localparam int unsigned NtscVSyncLen  = 3;
  localparam int unsigned NtscVActStart = 19;
  localparam int unsigned NtscVActLen   = 240;

  // PAL 240p-style progressive
  localparam int unsigned PalHTotal    = 794;
  localparam int unsigned PalHSyncLen  = 57;
  localparam int unsigned PalClampLen  = 8;
  localparam int unsigned PalHActStart = 128;
  localparam int unsigned PalHActLen   = 640;
  localparam int unsigned PalVTotal    = 313;
  localparam int unsigned PalVSyncLen  = 3;
  localparam int unsigned PalVActStart = 43;
  localparam int unsigned PalVActLen   = 240;

  typedef struct packed {
    logic n_vsync;
    logic n_clamp;
    logic n_hsync;
    logic n_csync;
  } sync_t;

  function automatic logic [VdWidth-1:0] pack_sync(sync_t s);
    logic [VdWidth-1:0] r;
    r             = '0;
    r[VdVsyncBit] = s.n_vsync;
    r[VdClampBit] = s.n_clamp;
    r[VdHsyncBit] = s.n_hsync;
    r[VdCsyncBit] = s.n_csync;
    return r;
  endfunction

endpackage

// File: rtl/n64_vtiming_gen.sv
// Phase/slot/line counters for the N64 video bus, plus the derived sync and active flags.
module n64_vtiming_gen
  import n64_vbus_tx_pkg::*;
#(
  parameter int unsigned H_TOTAL     = NtscHTotal,
  parameter int unsigned H_SYNC_LEN  = NtscHSyncLen,
  parameter int unsigned CLAMP_LEN   = NtscClampLen,
  parameter int unsigned H_ACT_START = NtscHActStart,
  parameter int unsigned H_ACT_LEN   = NtscHActLen,
  parameter int unsigned V_TOTAL     = NtscVTotal,
  parameter int unsigned V_SYNC_LEN  = NtscVSyncLen,
  parameter int unsigned V_ACT_START = NtscVActStart,
  parameter int unsigned V_ACT_LEN   = NtscVActLen
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic       run_o,
  output logic [1:0] phase_o,
  output sync_t      sync_o,
  output logic       active_o,
  output logic       origin_o
);

  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [8:0] VLast     = 9'(V_TOTAL - 1);
  localparam logic [9:0] HSyncEnd  = 10'(H_SYNC_LEN);
  localparam logic [9:0] ClampEnd  = 10'(H_SYNC_LEN + CLAMP_LEN);
  localparam logic [9:0] HActStart = 10'(H_ACT_START);
  localparam logic [9:0] HActEnd   = 10'(H_ACT_START + H_ACT_LEN);
  localparam logic [8:0] VSyncEnd  = 9'(V_SYNC_LEN);
  localparam logic [8:0] VActStart = 9'(V_ACT_START);
  localparam logic [8:0] VActEnd   = 9'(V_ACT_START + V_ACT_LEN);

  logic       run_q, run_d;
  logic [1:0] phase_q, phase_d;
  logic [9:0] h_q, h_d;
  logic [8:0] v_q, v_d;

  always_comb begin
    run_d   = run_q;
    phase_d = phase_q;
    h_d     = h_q;
    v_d     = v_q;
    if (!run_q) begin
      run_d = en_i;
    end else if (phase_q == 2'd3) begin
      phase_d = 2'd0;
      // EN_i is only honoured at a slot boundary so a started slot always completes.
      if (!en_i) begin
        run_d = 1'b0;
        h_d   = '0;
        v_d   = '0;
      end else if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? 9'd0 : v_q + 9'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      phase_d = phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      phase_q <= 2'd0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      run_q   <= run_d;
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    sync_o.n_hsync = (h_q >= HSyncEnd);
    sync_o.n_vsync = (v_q >= VSyncEnd);
    sync_o.n_csync = sync_o.n_hsync & sync_o.n_vsync;
    sync_o.n_clamp = !((h_q >= HSyncEnd) && (h_q < ClampEnd) && sync_o.n_vsync);
  end

  assign run_o    = run_q;
  assign phase_o  = phase_q;
  assign active_o = (h_q >= HActStart) && (h_q < HActEnd) && (v_q >= VActStart) &&
                    (v_q < VActEnd);
  assign origin_o = (h_q == 10'd0) && (v_q == 9'd0);

endmodule

// File: rtl/n64_vbus_tx.sv
// N64 digital video bus transmitter: serialises sync/R/G/B phases onto VD with the nVDSYNC
// strobe and pulls active pixels over a valid/ready handshake.
module n64_vbus_tx
  import n64_vbus_tx_pkg::*;
#(
  parameter int unsigned H_TOTAL     = NtscHTotal,
  parameter int unsigned H_SYNC_LEN  = NtscHSyncLen,
  parameter int unsigned CLAMP_LEN   = NtscClampLen,
  parameter int unsigned H_ACT_START = NtscHActStart,
  parameter int unsigned H_ACT_LEN   = NtscHActLen,
  parameter int unsigned V_TOTAL     = NtscVTotal,
  parameter int unsigned V_SYNC_LEN  = NtscVSyncLen,
  parameter int unsigned V_ACT_START = NtscVActStart,
  parameter int unsigned V_ACT_LEN   = NtscVActLen
) (
  input  logic        N64_CLK_i,
  input  logic        N64_RST_i,
  input  logic        EN_i,
  input  logic [20:0] PX_DATA_i,
  input  logic        PX_VALID_i,
  output logic        PX_READY_o,
  output logic        nVDSYNC_o,
  output logic [6:0]  VD_o,
  output logic        FRAME_START_o,
  output logic        UNDERFLOW_o,
  input  logic        UNDERFLOW_CLR_i
);

  if (H_TOTAL > 1024 || V_TOTAL > 512) begin : g_param_check
    $error("n64_vbus_tx: H_TOTAL must be <= 1024 and V_TOTAL <= 512");
  end

  logic       run;
  logic [1:0] phase;
  sync_t      sync;
  logic       active;
  logic       origin;

  n64_vtiming_gen #(
    .H_TOTAL     (H_TOTAL),
    .H_SYNC_LEN  (H_SYNC_LEN),
    .CLAMP_LEN   (CLAMP_LEN),
    .H_ACT_START (H_ACT_START),
    .H_ACT_LEN   (H_ACT_LEN),
    .V_TOTAL     (V_TOTAL),
    .V_SYNC_LEN  (V_SYNC_LEN),
    .V_ACT_START (V_ACT_START),
    .V_ACT_LEN   (V_ACT_LEN)
  ) u_timing (
    .clk_i    (N64_CLK_i),
    .rst_i    (N64_RST_i),
    .en_i     (EN_i),
    .run_o    (run),
    .phase_o  (phase),
    .sync_o   (sync),
    .active_o (active),
    .origin_o (origin)
  );

  logic        nvdsync_q, nvdsync_d;
  logic [6:0]  vd_q, vd_d;
  logic        frame_start_q, frame_start_d;
  logic        underflow_q, underflow_d;
  logic [20:0] px_q, px_d;
  logic        slot_take;

  assign slot_take  = run && (phase == 2'd0) && active;
  assign PX_READY_o = slot_take;

  always_comb begin
    nvdsync_d     = 1'b1;
    vd_d          = '0;
    frame_start_d = 1'b0;
    px_d          = px_q;
    underflow_d   = underflow_q;
    if (UNDERFLOW_CLR_i) underflow_d = 1'b0;
    if (run) begin
      unique case (phase)
        2'd0: begin
          nvdsync_d     = 1'b0;
          vd_d          = pack_sync(sync);
          frame_start_d = origin;
          // Blanking and starved slots both carry black on the colour phases.
          px_d          = (slot_take && PX_VALID_i) ? PX_DATA_i : 21'd0;
          if (slot_take && !PX_VALID_i) underflow_d = 1'b1;
        end
        2'd1: vd_d = px_q[20:14];
        2'd2: vd_d = px_q[13:7];
        2'd3: vd_d = px_q[6:0];
      endcase
    end
  end

  always_ff @(posedge N64_CLK_i) begin
    if (N64_RST_i) begin
      nvdsync_q     <= 1'b1;
      vd_q          <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      px_q          <= '0;
    end else begin
      nvdsync_q     <= nvdsync_d;
      vd_q          <= vd_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      px_q          <= px_d;
    end
  end

  assign nVDSYNC_o     = nvdsync_q;
  assign VD_o          = vd_q;
  assign FRAME_START_o = frame_start_q;
  assign UNDERFLOW_o   = underflow_q;

endmodule

// File: tb/tb_n64_vbus_tx.sv
// Self-checking bench for n64_vbus_tx using a reduced raster so whole frames fit in a short run.
module tb_n64_vbus_tx;

  localparam int HT  = 20;
  localparam int HS  = 3;
  localparam int CL  = 2;
  localparam int HA  = 7;
  localparam int HAL = 10;
  localparam int VT  = 12;
  localparam int VS  = 2;
  localparam int VA  = 4;
  localparam int VAL = 5;

  logic        clk = 1'b0;
  logic        rst, en, valid, clr;
  logic [20:0] data;
  logic        PX_READY_o, nVDSYNC_o, FRAME_START_o, UNDERFLOW_o;
  logic [6:0]  VD_o;

  int checks   = 0;
  int failures = 0;

  // Model: cycle count since the run started, plus latched pixel and sticky flag.
  bit          m_run = 0;
  int          m_n   = 0;
  logic [20:0] m_px  = '0;
  bit          m_uf  = 0;
  int          cyc   = 0;
  int          last_fs   = -1;
  int          frame_len = 0;
  int          ready_cnt = 0;

  n64_vbus_tx #(
    .H_TOTAL     (HT),
    .H_SYNC_LEN  (HS),
    .CLAMP_LEN   (CL),
    .H_ACT_START (HA),
    .H_ACT_LEN   (HAL),
    .V_TOTAL     (VT),
    .V_SYNC_LEN  (VS),
    .V_ACT_START (VA),
    .V_ACT_LEN   (VAL)
  ) dut (
    .N64_CLK_i       (clk),
    .N64_RST_i       (rst),
    .EN_i            (en),
    .PX_DATA_i       (data),
    .PX_VALID_i      (valid),
    .PX_READY_o      (PX_READY_o),
    .nVDSYNC_o       (nVDSYNC_o),
    .VD_o            (VD_o),
    .FRAME_START_o   (FRAME_START_o),
    .UNDERFLOW_o     (UNDERFLOW_o),
    .UNDERFLOW_CLR_i (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit act_at(int n);
    int s, h, v;
    s = n / 4;
    h = s % HT;
    v = (s / HT) % VT;
    return (h >= HA) && (h < HA + HAL) && (v >= VA) && (v < VA + VAL);
  endfunction

  function automatic logic [6:0] sync_bits(int h, int v);
    logic nhs, nvs, ncs, ncl;
    nhs = !(h < HS);
    nvs = !(v < VS);
    ncs = nhs & nvs;
    ncl = !((h >= HS) && (h < HS + CL) && nvs);
    return {3'b000, nvs, ncl, nhs, ncs};
  endfunction

  // Predict the outputs after the next edge from current inputs, then advance and compare.
  task automatic step();
    int ph, s, h, v, n_n;
    bit act, n_run, n_uf;
    logic e_nvd, e_fs;
    logic [6:0] e_vd;
    logic [20:0] n_px;
    ph  = m_n % 4;
    s   = m_n / 4;
    h   = s % HT;
    v   = (s / HT) % VT;
    act = act_at(m_n);
    chk("px_ready", {31'd0, PX_READY_o}, {31'd0, m_run && ph == 0 && act});
    if (PX_READY_o === 1'b1 && valid) ready_cnt++;
    e_nvd = 1'b1;
    e_vd  = '0;
    e_fs  = 1'b0;
    n_px  = m_px;
    n_uf  = m_uf && !clr;
    n_run = m_run;
    n_n   = m_n;
    if (rst) begin
      n_uf  = 0;
      n_px  = '0;
      n_run = 0;
      n_n   = 0;
    end else if (!m_run) begin
      n_run = en;
      n_n   = 0;
    end else begin
      case (ph)
        0: begin
          e_nvd = 1'b0;
          e_vd  = sync_bits(h, v);
          e_fs  = (h == 0) && (v == 0);
          n_px  = (act && valid) ? data : 21'd0;
          if (act && !valid) n_uf = 1;
        end
        1: e_vd = m_px[20:14];
        2: e_vd = m_px[13:7];
        default: e_vd = m_px[6:0];
      endcase
      if (ph == 3 && !en) begin
        n_run = 0;
        n_n   = 0;
      end else begin
        n_n = m_n + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("nvdsync", {31'd0, nVDSYNC_o}, {31'd0, e_nvd});
    chk("vd", {25'd0, VD_o}, {25'd0, e_vd});
    chk("frame_start", {31'd0, FRAME_START_o}, {31'd0, e_fs});
    chk("underflow", {31'd0, UNDERFLOW_o}, {31'd0, n_uf});
    if (FRAME_START_o === 1'b1) begin
      if (last_fs >= 0) frame_len = cyc - last_fs;
      last_fs = cyc;
    end
    m_run = n_run;
    m_n   = n_n;
    m_px  = n_px;
    m_uf  = n_uf;
    cyc++;
  endtask

  task automatic run_until(input string tag, input int ph, input bit need_act, input int limit);
    bit found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      if (m_run && (m_n % 4) == ph && (!need_act || act_at(m_n))) begin
        found = 1;
        break;
      end
      step();
    end
    if (!found) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b1;
    clr   = 1'b0;
    data  = {7'h55, 7'h2A, 7'h7F};
    #1;

    // Reset held with EN high: outputs idle throughout.
    for (int i = 0; i < 3; i++) step();
    chk("rst_nvdsync", {31'd0, nVDSYNC_o}, 32'd1);
    chk("rst_vd", {25'd0, VD_o}, 32'd0);

    // Release: run set at first edge, sync phase of (0,0) one clock later.
    rst = 1'b0;
    step();
    chk("start_idle", {31'd0, nVDSYNC_o}, 32'd1);
    step();
    chk("first_nvdsync", {31'd0, nVDSYNC_o}, 32'd0);
    chk("first_fs", {31'd0, FRAME_START_o}, 32'd1);
    chk("first_vd", {25'd0, VD_o}, 32'h04);

    // One full frame of constant valid pixels.
    ready_cnt = 0;
    for (int i = 0; i < 965; i++) step();
    chk("frame_len", frame_len, HT * VT * 4);
    chk("ready_per_frame", ready_cnt, HAL * VAL);

    // Randomised pixels, valid gaps and clear pulses.
    for (int i = 0; i < 2000; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = 21'($urandom);
      clr   = ($urandom_range(0, 7) == 0);
      step();
    end

    // Clear coincident with a fresh underflow keeps the flag set.
    valid = 1'b1;
    clr   = 1'b0;
    run_until("timeout_uf_slot", 0, 1, 2000);
    valid = 1'b0;
    clr   = 1'b1;
    step();
    chk("uf_set_wins", {31'd0, UNDERFLOW_o}, 32'd1);
    valid = 1'b1;
    step();
    chk("uf_cleared", {31'd0, UNDERFLOW_o}, 32'd0);
    clr = 1'b0;
    for (int i = 0; i < 2; i++) step();

    // EN drop at phase 1: slot completes, then idle; re-enable restarts at (0,0).
    run_until("timeout_en_drop", 1, 0, 100);
    en = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("drop_idle_nvd", {31'd0, nVDSYNC_o}, 32'd1);
    chk("drop_idle_vd", {25'd0, VD_o}, 32'd0);
    en = 1'b1;
    step();
    step();
    chk("restart_fs", {31'd0, FRAME_START_o}, 32'd1);

    // Reset at phase 2 of an active slot: B phase never appears.
    data = {7'h11, 7'h22, 7'h33};
    run_until("timeout_rst_slot", 2, 1, 2000);
    rst = 1'b1;
    step();
    chk("midrst_vd", {25'd0, VD_o}, 32'd0);
    chk("midrst_nvd", {31'd0, nVDSYNC_o}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
